// File: rtl/rgb_to_ycbcr.sv
// RGB888 -> JFIF YCbCr stream converter: 3-stage stallable pipeline plus a
// frame tracker. Define RGB_TO_YCBCR_ROUND_EN for round-half-up instead of floor.
module rgb_to_ycbcr #(
    parameter int HEIGHT              = 480,
    parameter int PIXEL_BITWIDTH      = 8,
    parameter int LINE_COUNT_BITWIDTH = $clog2(HEIGHT) + 1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [3*PIXEL_BITWIDTH-1:0] i_rgb,
    input  logic                        i_tuser,
    input  logic                        i_tlast,
    input  logic                        i_tvalid,
    input  logic                        i_wait,
    output logic                        o_wait,
    output logic [PIXEL_BITWIDTH-1:0]   o_y,
    output logic [PIXEL_BITWIDTH-1:0]   o_cb,
    output logic [PIXEL_BITWIDTH-1:0]   o_cr,
    output logic                        o_tuser,
    output logic                        o_tlast,
    output logic                        o_tvalid,
    output logic                        o_frame_end
);
    localparam int PB  = PIXEL_BITWIDTH;
    localparam int LCB = LINE_COUNT_BITWIDTH;

`ifdef RGB_TO_YCBCR_ROUND_EN
    localparam logic signed [18:0] ROUND = 19'sd128;
`else
    localparam logic signed [18:0] ROUND = 19'sd0;
`endif
    localparam logic signed [18:0] OFFSET = 19'sd32768;

    // Row-major: Y, Cb, Cr rows; R, G, B columns.
    localparam logic signed [17:0] COEF [9] = '{
        18'sd77,  18'sd150,  18'sd29,
        -18'sd43, -18'sd85,  18'sd128,
        18'sd128, -18'sd107, -18'sd21
    };

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic vld;
        logic tuser;
        logic tlast;
        logic frame_end;
    } side_t;

    state_t           state;
    logic [LCB-1:0]   line_count;
    logic [LCB-1:0]   eff_line;
    logic             accept;
    logic             last_line;
    logic             frame_end_tag;
    logic signed [17:0] chan [3];
    logic signed [17:0] prod [9];
    logic signed [18:0] sum_y, sum_cb, sum_cr;
    side_t            s1, s2, s3;

    function automatic logic signed [18:0] sx(input logic signed [17:0] v);
        return {v[17], v};
    endfunction

    function automatic logic [PB-1:0] clamp(input logic signed [18:0] s);
        if (s[18])
            return '0;
        else if (|s[17:16])
            return '1;
        else
            return s[8 +: PB];
    endfunction

    assign o_wait = i_wait;

    always_comb begin
        for (int c = 0; c < 3; c++)
            chan[c] = $signed({{(18-PB){1'b0}}, i_rgb[(2-c)*PB +: PB]});
        accept        = i_tvalid & ~i_wait & ((state == ACTIVE) | i_tuser);
        // A tuser beat restarts the frame before its tlast is counted.
        eff_line      = i_tuser ? '0 : line_count;
        last_line     = (eff_line == LCB'(HEIGHT - 1));
        frame_end_tag = accept & i_tlast & last_line;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            line_count <= '0;
        end else if (accept) begin
            if (i_tlast) begin
                if (last_line) begin
                    state      <= IDLE;
                    line_count <= '0;
                end else begin
                    state      <= ACTIVE;
                    line_count <= eff_line + LCB'(1);
                end
            end else if (i_tuser) begin
                state      <= ACTIVE;
                line_count <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < 9; i++)
                prod[i] <= '0;
            sum_y  <= '0;
            sum_cb <= '0;
            sum_cr <= '0;
            o_y    <= '0;
            o_cb   <= '0;
            o_cr   <= '0;
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
        end else if (!i_wait) begin
            for (int i = 0; i < 9; i++)
                prod[i] <= COEF[i] * chan[i % 3];
            s1 <= '{vld: accept, tuser: accept & i_tuser,
                    tlast: accept & i_tlast, frame_end: frame_end_tag};

            sum_y  <= sx(prod[0]) + sx(prod[1]) + sx(prod[2]) + ROUND;
            sum_cb <= sx(prod[3]) + sx(prod[4]) + sx(prod[5]) + OFFSET + ROUND;
            sum_cr <= sx(prod[6]) + sx(prod[7]) + sx(prod[8]) + OFFSET + ROUND;
            s2     <= s1;

            o_y  <= clamp(sum_y);
            o_cb <= clamp(sum_cb);
            o_cr <= clamp(sum_cr);
            s3   <= s2;
        end
    end

    assign o_tvalid    = s3.vld;
    assign o_tuser     = s3.tuser;
    assign o_tlast     = s3.tlast;
    assign o_frame_end = s3.frame_end;

endmodule

// File: doc/rgb_to_ycbcr.md
Name: rgb_to_ycbcr

Overview:
- Pixel-stream colour converter sitting directly upstream of the MCU splitter stage.
- Takes 8-bit-per-channel RGB raster beats with tuser (start of frame), tlast (end of line) and tvalid.
- Emits JFIF YCbCr beats with the sideband aligned to them; the Y, Cb and Cr planes then feed per-component MCU splitting.
- 3-stage stallable pipeline, plus a frame-tracking FSM that drops pre-frame garbage and flags end of frame.

Parameters:
- HEIGHT, 480, lines per frame; the end-of-frame line count.
- PIXEL_BITWIDTH, 8, bits per colour component in and out. Coefficients are fixed for 8.
- LINE_COUNT_BITWIDTH, $clog2(HEIGHT)+1, line counter width (derived).

Ports:
- clk  in  1  clock.
- n_rst  in  1  synchronous, active-low reset.
- i_rgb  in  3*PIXEL_BITWIDTH  R at [23:16], G at [15:8], B at [7:0].
- i_tuser  in  1  first pixel of frame.
- i_tlast  in  1  last pixel of line.
- i_tvalid  in  1  input beat valid.
- i_wait  in  1  downstream stall; holds the whole pipeline.
- o_wait  out  1  upstream stall = i_wait (combinational).
- o_y  out  PIXEL_BITWIDTH  luma.
- o_cb  out  PIXEL_BITWIDTH  blue-difference chroma.
- o_cr  out  PIXEL_BITWIDTH  red-difference chroma.
- o_tuser  out  1  delayed i_tuser.
- o_tlast  out  1  delayed i_tlast.
- o_tvalid  out  1  output beat valid.
- o_frame_end  out  1  high with the last output beat of line HEIGHT-1.

Behaviour:
- Reset:
  - All outputs 0; all stage valids 0.
  - FSM in IDLE; line_count 0.
  - Reset mid-frame discards in-flight beats.
- Stall: when i_wait=1, every pipeline register, valid, sideband bit, the FSM and line_count hold.
- Beat acceptance: a beat is accepted when i_tvalid & !i_wait & (FSM accepts it).
  - Accepted beats enter stage 1 with valid=1.
  - Any other non-stalled cycle inserts a bubble (valid=0).
- Latency: exactly 3 non-stalled cycles from acceptance to o_tvalid=1. Order is preserved; bubbles propagate unchanged.
- Fixed-point coefficients (Q8, signed):
  - Y = 77R + 150G + 29B
  - Cb = -43R - 85G + 128B + 32768
  - Cr = 128R - 107G - 21B + 32768
- Stage 1: nine products registered, each 18-bit signed.
- Stage 2: three sums registered, 19-bit signed; the 32768 offset is added to the chroma sums here.
- Stage 3: arithmetic shift right by 8, clamp to [0,255], registered to o_y/o_cb/o_cr. The sum is truncated unless the optional feature is enabled.
- Sideband: tuser, tlast and frame_end travel with their beat through all 3 stages.
- FSM states:
  - IDLE:
    - Beats without i_tuser are dropped (not accepted, bubble inserted).
    - A valid beat with i_tuser is accepted; line_count=0; go to ACTIVE.
  - ACTIVE:
    - All valid beats are accepted.
    - On an accepted i_tlast beat: if line_count==HEIGHT-1, tag the beat frame_end=1, set line_count=0 and go to IDLE; else line_count+1.
- Simultaneous events:
  - i_tuser in ACTIVE restarts the frame: line_count=0, beat accepted.
  - tuser and tlast on the same beat: the restart is applied first, then tlast counts it as line 0.
- o_wait never depends on FSM state.

Optional Feature:
- Macro RGB_TO_YCBCR_ROUND_EN.
- Defined: stage 2 also adds 128 to all three sums (round half up) before the stage-3 shift.
- Undefined: truncation (floor).
- Latency and interface are identical either way.

Test Plan:
- White (255,255,255), tuser=1, wait=0 -> 3 cycles later Y=255, Cb=128, Cr=128, o_tuser=1, o_tvalid=1.
- Pure red (255,0,0) -> Y=76 (77 with ROUND_EN), Cb=85, Cr=255 (clamped from 256 under ROUND_EN).
- Pure blue (0,0,255) -> Y=28 (29 with ROUND_EN), Cb=255, Cr=107.
- 5 beats without tuser, then a tuser beat -> the first 5 produce no o_tvalid; the tuser beat appears 3 cycles later.
- HEIGHT=4, 4 tlast lines, i_wait asserted 2 cycles mid-stream -> outputs frozen during the wait; o_frame_end=1 only with the 4th o_tlast; next non-tuser beat dropped.
- n_rst low for 1 cycle mid-line with 2 beats in flight -> o_tvalid=0 next cycle; the in-flight beats never appear; FSM waits for tuser.
